// File: rtl/femtosoc_mem_ctrl_if.sv
// femtosoc_mem_ctrl_if: FemtoRV32 memory port bundle between core and memory/IO slave
// Signals: mem_addr/mem_wdata/mem_wmask/mem_rstrb (core -> slave), mem_rdata/mem_rbusy/mem_wbusy (slave -> core)
interface femtosoc_mem_ctrl_if;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_rstrb;
   logic [31:0] mem_rdata;
   logic        mem_rbusy;
   logic        mem_wbusy;
   modport master (output mem_addr, mem_wdata, mem_wmask, mem_rstrb, input mem_rdata, mem_rbusy, mem_wbusy);
   modport slave (input mem_addr, mem_wdata, mem_wmask, mem_rstrb, output mem_rdata, mem_rbusy, mem_wbusy);
endinterface

// File: rtl/femtosoc_mem_ctrl.sv
// femtosoc_mem_ctrl: FemtoRV32 memory/IO slave with byte-maskable RAM, LED register and buffered UART transmitter
// Ports: clk, reset (sync, active-low), bus (slave side of the core memory port), leds (LED register), uart_tx (serial out, idle high)
module femtosoc_mem_ctrl #(
   parameter int RAM_WORDS = 4096,
   parameter int RAM_WAIT  = 0,
   parameter int BAUD_DIV  = 217,
   parameter int LED_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   femtosoc_mem_ctrl_if.slave   bus,
   output logic [LED_WIDTH-1:0] leds,
   output logic                 uart_tx
);
   localparam int AW = $clog2(RAM_WORDS);
   localparam int BW = $clog2(BAUD_DIV + 1);
   logic [31:0] ram [RAM_WORDS];
   logic [AW-1:0] idx;
   logic is_io, wr, rd_go, sel_led, sel_udat, sel_stat;
   logic [31:0] io_word, rd_word, rd_buf;
   logic [2:0] wait_cnt;
   logic holding_full, overrun, active, tx_busy, last_baud, frame_end, load;
   logic [7:0] hold_data;
   logic [8:0] shreg;
   logic [3:0] bit_cnt;
   logic [BW-1:0] baud_cnt;
   logic unused_bits;
   assign unused_bits = ^{bus.mem_addr, bus.mem_wdata};
   assign idx = bus.mem_addr[AW+1:2];
   assign is_io = bus.mem_addr[22];
   assign wr = |bus.mem_wmask;
   assign rd_go = bus.mem_rstrb && !bus.mem_rbusy;
   assign sel_led = is_io && bus.mem_addr[2];
   assign sel_udat = is_io && bus.mem_addr[3];
   assign sel_stat = is_io && bus.mem_addr[4];
   assign tx_busy = holding_full || active;
   assign io_word = (sel_led ? 32'(leds) : 32'd0) | (sel_stat ? {30'd0, overrun, tx_busy} : 32'd0);
   assign rd_word = is_io ? io_word : ram[idx];
   assign last_baud = baud_cnt == BW'(BAUD_DIV - 1);
   assign frame_end = active && last_baud && bit_cnt == 4'd9;
   // a pending byte loads on the edge that ends the stop bit, so frames are back-to-back
   assign load = holding_full && (!active || frame_end);
   assign bus.mem_wbusy = holding_full;
   always_ff @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (wr && !is_io && bus.mem_wmask[i]) ram[idx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
   // RAM data is captured at the strobe edge (read-before-write) and released after RAM_WAIT cycles
   always_ff @(posedge clk) begin
      if (!reset) begin
         bus.mem_rdata <= '0;
         bus.mem_rbusy <= 1'b0;
         wait_cnt <= '0;
         rd_buf <= '0;
      end else if (rd_go) begin
         if (RAM_WAIT == 0 || is_io) bus.mem_rdata <= rd_word;
         else begin
            bus.mem_rbusy <= 1'b1;
            wait_cnt <= 3'(RAM_WAIT);
            rd_buf <= rd_word;
         end
      end else if (bus.mem_rbusy) begin
         wait_cnt <= wait_cnt - 3'd1;
         if (wait_cnt == 3'd1) begin
            bus.mem_rbusy <= 1'b0;
            bus.mem_rdata <= rd_buf;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         leds <= '0;
         uart_tx <= 1'b1;
         holding_full <= 1'b0;
         hold_data <= '0;
         overrun <= 1'b0;
         active <= 1'b0;
         shreg <= '0;
         bit_cnt <= '0;
         baud_cnt <= '0;
      end else begin
         if (wr && sel_led && bus.mem_wmask[0]) leds <= bus.mem_wdata[LED_WIDTH-1:0];
         if (rd_go && sel_stat) overrun <= 1'b0;
         if (wr && sel_udat && bus.mem_wmask[0]) begin
            if (holding_full) overrun <= 1'b1;
            else begin
               holding_full <= 1'b1;
               hold_data <= bus.mem_wdata[7:0];
            end
         end
         // bit_cnt: 0 = start, 1..8 = data, 9 = stop; shreg holds the bits still to send
         if (load) begin
            active <= 1'b1;
            holding_full <= 1'b0;
            uart_tx <= 1'b0;
            shreg <= {1'b1, hold_data};
            bit_cnt <= '0;
            baud_cnt <= '0;
         end else if (active) begin
            baud_cnt <= last_baud ? '0 : baud_cnt + 1'b1;
            if (last_baud) begin
               if (bit_cnt == 4'd9) active <= 1'b0;
               else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  uart_tx <= shreg[0];
                  shreg <= shreg >> 1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_femtosoc_mem_ctrl.sv
// tb_femtosoc_mem_ctrl: self-checking bench driving a zero-wait and a three-wait instance with shared stimulus
// Ports: none; checks RAM masking/aliasing/wait states, LED and UART behaviour against a byte-level memory model
module tb_femtosoc_mem_ctrl;
   localparam int RW = 64;
   localparam int D = 4;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0] wmask = '0;
   logic rstrb = 1'b0;
   logic [7:0] leds0, leds3;
   logic tx0, tx3;
   int n_chk = 0, n_fail = 0;
   logic [7:0] mdl [RW*4];
   femtosoc_mem_ctrl_if b0 ();
   femtosoc_mem_ctrl_if b3 ();
   assign b0.mem_addr = addr;
   assign b0.mem_wdata = wdata;
   assign b0.mem_wmask = wmask;
   assign b0.mem_rstrb = rstrb;
   assign b3.mem_addr = addr;
   assign b3.mem_wdata = wdata;
   assign b3.mem_wmask = wmask;
   assign b3.mem_rstrb = rstrb;
   femtosoc_mem_ctrl #(.RAM_WORDS(RW), .RAM_WAIT(0), .BAUD_DIV(D), .LED_WIDTH(8)) dut0 (
      .clk(clk), .reset(reset), .bus(b0), .leds(leds0), .uart_tx(tx0));
   femtosoc_mem_ctrl #(.RAM_WORDS(RW), .RAM_WAIT(3), .BAUD_DIV(D), .LED_WIDTH(8)) dut3 (
      .clk(clk), .reset(reset), .bus(b3), .leds(leds3), .uart_tx(tx3));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % RW);
   endfunction
   function automatic logic [31:0] mword(input logic [31:0] a);
      int w = widx(a);
      return {mdl[w*4+3], mdl[w*4+2], mdl[w*4+1], mdl[w*4]};
   endfunction
   // serial line level k cycles into a frame carrying byte b
   function automatic logic fbit(input logic [7:0] b, input int k);
      int p = k / D;
      return p == 0 ? 1'b0 : p >= 9 ? 1'b1 : b[p-1];
   endfunction
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      int w = widx(a);
      addr = a;
      wdata = d;
      wmask = m;
      if (!a[22]) for (int i = 0; i < 4; i++) if (m[i]) mdl[w*4+i] = d[8*i +: 8];
      tick();
      wmask = '0;
   endtask
   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      rstrb = 1'b1;
      tick();
      rstrb = 1'b0;
      chk({tag, " d0"}, b0.mem_rdata, exp);
      chk({tag, " rbusy0"}, b0.mem_rbusy, 0);
      if (!a[22])
         for (int k = 0; k < 3; k++) begin
            chk({tag, " rbusy3 wait"}, b3.mem_rbusy, 1);
            tick();
         end
      chk({tag, " d3"}, b3.mem_rdata, exp);
      chk({tag, " rbusy3 done"}, b3.mem_rbusy, 0);
   endtask
   initial begin
      logic [31:0] a, old;
      logic [127:0] got_tx, exp_tx, got_wb, exp_wb;
      repeat (3) tick();
      reset = 1'b1;
      chk("rst leds", leds0, 0);
      chk("rst tx", tx0, 1);
      chk("rst rbusy", b0.mem_rbusy, 0);
      chk("rst wbusy", b0.mem_wbusy, 0);
      chk("rst rdata", b0.mem_rdata, 0);
      chk("rst tx3", tx3, 1);
      for (int w = 0; w < RW; w++) wr(32'(w * 4), $urandom, 4'hF);
      wr(32'h10, 32'hDEADBEEF, 4'hF);
      wr(32'h10, 32'h00AA0000, 4'b0100);
      rd("mask", 32'h10, 32'hDEAABEEF);
      wr(32'h0, 32'h12345678, 4'hF);
      rd("alias", 32'(RW * 4), 32'h12345678);
      old = mword(32'h20);
      rstrb = 1'b1;
      wr(32'h20, 32'hCAFEF00D, 4'hF);
      rstrb = 1'b0;
      chk("rbw d0", b0.mem_rdata, old);
      for (int k = 0; k < 3; k++) begin
         chk("rbw rbusy3", b3.mem_rbusy, 1);
         tick();
      end
      chk("rbw d3", b3.mem_rdata, old);
      rd("rbw new", 32'h20, 32'hCAFEF00D);
      wr(32'h30, 32'h11111111, 4'hF);
      wr(32'h34, 32'h22222222, 4'hF);
      addr = 32'h30;
      rstrb = 1'b1;
      tick();
      addr = 32'h34;
      tick();
      rstrb = 1'b0;
      chk("ign d0", b0.mem_rdata, 32'h22222222);
      repeat (2) tick();
      chk("ign d3", b3.mem_rdata, 32'h11111111);
      chk("ign rbusy3", b3.mem_rbusy, 0);
      tick();
      chk("ign rbusy3 after", b3.mem_rbusy, 0);
      repeat (60) begin
         a = $urandom & 32'h003F_FFFC;
         if ($urandom_range(1) == 1) wr(a, $urandom, 4'($urandom_range(15)));
         else rd("rand", a, mword(a));
      end
      wr(32'h400004, 32'h000000A5, 4'b0001);
      chk("led", leds0, 8'hA5);
      chk("led3", leds3, 8'hA5);
      wr(32'h400004, 32'h000000FF, 4'b0010);
      chk("led nomask", leds0, 8'hA5);
      rd("led rd", 32'h400004, 32'hA5);
      rd("udat rd", 32'h400008, 0);
      rd("stat idle", 32'h400010, 0);
      rd("multi rd", 32'h400014, 32'hA5);
      wr(32'h400008, 32'h55, 4'b0001);
      chk("u1 wbusy hi", b0.mem_wbusy, 1);
      tick();
      chk("u1 wbusy lo", b0.mem_wbusy, 0);
      got_tx = '0;
      exp_tx = '0;
      for (int k = 0; k <= 40; k++) begin
         got_tx[k] = tx0;
         exp_tx[k] = k < 40 ? fbit(8'h55, k) : 1'b1;
         if (k == 10) begin
            addr = 32'h400010;
            rstrb = 1'b1;
         end
         if (k == 11) begin
            rstrb = 1'b0;
            chk("u1 stat mid", b0.mem_rdata, 1);
         end
         tick();
      end
      chk("u1 frame", got_tx, exp_tx);
      rd("u1 stat after", 32'h400010, 0);
      wr(32'h400008, 32'h41, 4'b0001);
      chk("u2 wbusy first", b0.mem_wbusy, 1);
      tick();
      got_tx = '0;
      exp_tx = '0;
      got_wb = '0;
      exp_wb = '0;
      for (int k = 0; k < 90; k++) begin
         got_tx[k] = tx0;
         got_wb[k] = b0.mem_wbusy;
         exp_tx[k] = k < 40 ? fbit(8'h41, k) : k < 80 ? fbit(8'h42, k - 40) : 1'b1;
         exp_wb[k] = k >= 1 && k < 40;
         if (k == 0) begin
            addr = 32'h400008;
            wdata = 32'h42;
            wmask = 4'b0001;
         end
         if (k == 1) wmask = '0;
         if (k == 3) begin
            wdata = 32'h43;
            wmask = 4'b0001;
         end
         if (k == 4) begin
            wmask = '0;
            addr = 32'h400010;
            rstrb = 1'b1;
         end
         if (k == 5) begin
            rstrb = 1'b0;
            chk("u2 stat overrun", b0.mem_rdata, 3);
         end
         if (k == 6) rstrb = 1'b1;
         if (k == 7) begin
            rstrb = 1'b0;
            chk("u2 stat cleared", b0.mem_rdata, 1);
         end
         tick();
      end
      chk("u2 frames", got_tx, exp_tx);
      chk("u2 wbusy", got_wb, exp_wb);
      chk("u2 frames dut3", tx3, 1);
      rd("u2 stat end", 32'h400010, 0);
      wr(32'h400008, 32'hF0, 4'b0001);
      repeat (10) tick();
      chk("mid tx low", tx0, 0);
      reset = 1'b0;
      tick();
      chk("mid rst tx", tx0, 1);
      chk("mid rst wbusy", b0.mem_wbusy, 0);
      chk("mid rst leds", leds0, 0);
      chk("mid rst rdata", b0.mem_rdata, 0);
      reset = 1'b1;
      repeat (5) tick();
      chk("mid rst idle tx", tx0, 1);
      rd("mid rst stat", 32'h400010, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
